edge_param_loader: RTL

- Upstream feeder for a group of neighbor links: holds per-context weight and boundary condition for NUM_EDGES edges.
- Drives each link's weight_in / boundary_condition_in for the currently active context.
- Accepts parameter writes over a valid/ready stream during STAGE_PARAMETERS_LOADING.
- Advances its context pointer in lockstep with the links' context memory rotation.

---
 rtl/edge_param_loader_if.sv | 24 ++
 rtl/edge_param_loader.sv | 115 +++++++++++
 2 files changed

// File: rtl/edge_param_loader_if.sv
// Parameter-load write stream: the controller (master) offers one (context, edge)
// entry per cycle, and the loader (slave) accepts it on valid & ready.
interface edge_param_loader_if #(
  parameter int CW  = 1,
  parameter int EW  = 2,
  parameter int LBW = 2
);
  logic           load_valid;
  logic           load_ready;
  logic [CW-1:0]  load_context;
  logic [EW-1:0]  load_edge;
  logic [LBW-1:0] load_weight;
  logic [1:0]     load_bc;

  modport master (
    output load_valid, load_context, load_edge, load_weight, load_bc,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_context, load_edge, load_weight, load_bc,
    output load_ready
  );
endinterface

// File: rtl/edge_param_loader.sv
// Per-context weight / boundary-condition store feeding NUM_EDGES neighbor links.
// It presents the active context's entries and steps contexts in lockstep with the links.
module edge_param_loader #(
  parameter int MAX_WEIGHT   = 2,
  parameter int NUM_CONTEXTS = 2,
  parameter int NUM_EDGES    = 4,
  parameter int STAGE_WIDTH  = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE               = STAGE_WIDTH'(0),
  parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = STAGE_WIDTH'(1),
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM       = STAGE_WIDTH'(2),
  localparam int LBW = $clog2(MAX_WEIGHT + 1),
  localparam int CW  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
  localparam int EW  = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STAGE_WIDTH-1:0]    global_stage,
  input  logic                      do_not_store,
  input  logic                      param_clear,
  edge_param_loader_if.slave        load,
  output logic [NUM_EDGES*LBW-1:0]  weight_out,
  output logic [NUM_EDGES*2-1:0]    boundary_condition_out,
  output logic [CW-1:0]             active_context,
  output logic                      all_loaded,
  output logic                      load_error
);

  logic [STAGE_WIDTH-1:0]                  stage;
  logic [LBW-1:0]                          weight_mem [NUM_CONTEXTS][NUM_EDGES];
  logic [1:0]                              bc_mem     [NUM_CONTEXTS][NUM_EDGES];
  logic [NUM_CONTEXTS-1:0][NUM_EDGES-1:0]  loaded;

  logic           load_ready;
  logic           accept;
  logic           in_range;
  logic           advance;
  logic [LBW-1:0] clamped_weight;
  logic [CW-1:0]  next_context;

  assign load_ready      = (stage == STAGE_PARAMETERS_LOADING);
  assign load.load_ready = load_ready;
  assign all_loaded      = &loaded;

  always_comb begin
    accept         = load.load_valid && load_ready;
    in_range       = (32'(load.load_context) < NUM_CONTEXTS) && (32'(load.load_edge) < NUM_EDGES);
    advance        = (stage == STAGE_WRITE_TO_MEM) && !do_not_store;
    clamped_weight = load.load_weight;
    if (32'(load.load_weight) > MAX_WEIGHT) begin
      clamped_weight = LBW'(MAX_WEIGHT);
    end
    next_context = active_context + 1'b1;
    if (active_context == CW'(NUM_CONTEXTS - 1)) begin
      next_context = '0;
    end
  end

  // Clear is applied first so a write landing in the same cycle still sets its bit / error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage          <= STAGE_IDLE;
      active_context <= '0;
      loaded         <= '0;
      load_error     <= 1'b0;
    end else begin
      stage <= global_stage;
      if (param_clear) begin
        active_context <= '0;
      end else if (advance) begin
        active_context <= next_context;
      end
      if (param_clear) begin
        loaded     <= '0;
        load_error <= 1'b0;
      end
      if (accept) begin
        if (in_range) begin
          loaded[load.load_context][load.load_edge] <= 1'b1;
        end else begin
          load_error <= 1'b1;
        end
      end
    end
  end

  // Storage survives param_clear; only reset returns it to the "non-existent edge" default.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CONTEXTS; c++) begin
        for (int e = 0; e < NUM_EDGES; e++) begin
          weight_mem[c][e] <= '0;
          bc_mem[c][e]     <= 2'b10;
        end
      end
    end else if (accept && in_range) begin
      weight_mem[load.load_context][load.load_edge] <= clamped_weight;
      bc_mem[load.load_context][load.load_edge]     <= load.load_bc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < NUM_EDGES; e++) begin
        weight_out[e*LBW +: LBW]           <= '0;
        boundary_condition_out[e*2 +: 2]   <= 2'b10;
      end
    end else begin
      for (int e = 0; e < NUM_EDGES; e++) begin
        weight_out[e*LBW +: LBW]           <= weight_mem[active_context][e];
        boundary_condition_out[e*2 +: 2]   <= bc_mem[active_context][e];
      end
    end
  end

endmodule
